// File: rtl/t1_run_controller.sv
// t1_run_controller: clocked run sequencer for the T1 emulation top.
// Holds all reset domains, releases them one by one with a fixed stagger,
// generates the init window, runs a commit-interval watchdog and qualifies
// the DPI finish request against per-domain idle before signalling done.
// Optional trace window (dump_start/dump_end/dump_active, error_code 3) is
// compiled in when the macro T1_TRACE_WINDOW_EN is defined.
module t1_run_controller #(
   parameter int unsigned NUM_DOMAINS        = 2,
   parameter int unsigned RESET_HOLD_CYCLES  = 5,
   parameter int unsigned STAGGER_CYCLES     = 2,
   parameter int unsigned INIT_CYCLES        = 1,
   parameter int unsigned WATCHDOG_WIDTH     = 32,
   parameter int unsigned CYCLE_WIDTH        = 64,
   parameter int unsigned IDLE_STABLE_CYCLES = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      commit_valid,
   input  logic                      finish_req,
   input  logic [NUM_DOMAINS-1:0]    idle,
   input  logic [WATCHDOG_WIDTH-1:0] wdg_limit,
`ifdef T1_TRACE_WINDOW_EN
   input  logic [CYCLE_WIDTH-1:0]    dump_start,
   input  logic [CYCLE_WIDTH-1:0]    dump_end,
   output logic                      dump_active,
`endif
   output logic [NUM_DOMAINS-1:0]    domain_reset,
   output logic                      init_flag,
   output logic [CYCLE_WIDTH-1:0]    cycle,
   output logic [2:0]                state,
   output logic                      done,
   output logic                      timeout,
   output logic [7:0]                error_code
);

   localparam int unsigned HOLD_EFF = (RESET_HOLD_CYCLES == 0) ? 1 : RESET_HOLD_CYCLES;
   localparam int unsigned IDLE_EFF = (IDLE_STABLE_CYCLES == 0) ? 1 : IDLE_STABLE_CYCLES;
   localparam int unsigned LAST_REL = (NUM_DOMAINS - 1) * STAGGER_CYCLES;

   typedef enum logic [2:0] {
      S_HOLD    = 3'd0,
      S_RELEASE = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   state_t                    st, st_nxt;
   logic [31:0]               hold_cnt;
   logic [31:0]               rel_cnt;
   logic [31:0]               idle_cnt;
   logic [WATCHDOG_WIDTH-1:0] wdg_cnt;

   logic                      active;
   logic                      watching;
   logic [CYCLE_WIDTH-1:0]    cycle_nxt;
   logic                      hold_done;
   logic                      rel_step;
   logic [31:0]               rel_elapsed;
   logic                      rel_last;
   logic                      wdg_fire;
   logic                      idle_done;
   logic                      trace_end;

   // Shared qualifiers for the FSM and the datapath
   always_comb begin
      active      = (st == S_HOLD) || (st == S_RELEASE) || (st == S_RUN) || (st == S_DRAIN);
      watching    = (st == S_RUN) || (st == S_DRAIN);
      cycle_nxt   = (active && (cycle != '1)) ? cycle + CYCLE_WIDTH'(1) : cycle;
      hold_done   = (st == S_HOLD) && (hold_cnt == HOLD_EFF - 1);
      // Elapsed counts from the RELEASE entry edge (0 on that edge itself),
      // so domain 0 and, with no stagger, every domain drop on the entry edge.
      rel_step    = hold_done || (st == S_RELEASE);
      rel_elapsed = (st == S_RELEASE) ? rel_cnt + 32'd1 : 32'd0;
      rel_last    = rel_step && (rel_elapsed >= LAST_REL);
      wdg_fire    = watching && (wdg_limit != '0) && !commit_valid &&
                    (({1'b0, wdg_cnt} + {{WATCHDOG_WIDTH{1'b0}}, 1'b1}) == {1'b0, wdg_limit});
      idle_done   = (st == S_DRAIN) && (&idle) && (idle_cnt + 32'd1 >= IDLE_EFF);
`ifdef T1_TRACE_WINDOW_EN
      trace_end   = watching && (dump_end != '0) && (cycle_nxt == dump_end);
`else
      trace_end   = 1'b0;
`endif
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset) st <= S_HOLD;
      else        st <= st_nxt;
   end

   // Next-state logic; watchdog outranks trace end, which outranks finish/idle
   always_comb begin
      st_nxt = st;
      case (st)
         S_HOLD:    if (hold_done) st_nxt = rel_last ? S_RUN : S_RELEASE;
         S_RELEASE: if (rel_last) st_nxt = S_RUN;
         S_RUN: begin
            if (wdg_fire || trace_end) st_nxt = S_FAULT;
            else if (finish_req)       st_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (wdg_fire || trace_end) st_nxt = S_FAULT;
            else if (idle_done)        st_nxt = S_DONE;
         end
         S_DONE:    st_nxt = S_DONE;
         S_FAULT:   st_nxt = S_FAULT;
         default:   st_nxt = S_HOLD;
      endcase
   end

   // Counters, domain resets, init window and fault code
   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle        <= '0;
         init_flag    <= 1'b1;
         domain_reset <= '1;
         hold_cnt     <= '0;
         rel_cnt      <= '0;
         idle_cnt     <= '0;
         wdg_cnt      <= '0;
         error_code   <= '0;
`ifdef T1_TRACE_WINDOW_EN
         dump_active  <= 1'b0;
`endif
      end else begin
         cycle <= cycle_nxt;
         if (cycle_nxt >= CYCLE_WIDTH'(INIT_CYCLES)) init_flag <= 1'b0;
         if ((st == S_HOLD) && !hold_done) hold_cnt <= hold_cnt + 32'd1;
         if (st == S_RELEASE) rel_cnt <= rel_cnt + 32'd1;
         if (rel_step) begin
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
               if (rel_elapsed >= i * STAGGER_CYCLES) domain_reset[i] <= 1'b0;
            end
         end
         if ((st_nxt == S_RUN) && (st != S_RUN)) wdg_cnt <= '0;
         else if (watching) begin
            if (commit_valid)       wdg_cnt <= '0;
            else if (wdg_cnt != '1) wdg_cnt <= wdg_cnt + WATCHDOG_WIDTH'(1);
         end
         if ((st == S_DRAIN) && (&idle)) idle_cnt <= idle_cnt + 32'd1;
         else                            idle_cnt <= '0;
         if ((st_nxt == S_FAULT) && (st != S_FAULT)) begin
            if (wdg_fire) error_code <= (st == S_RUN) ? 8'd1 : 8'd2;
            else          error_code <= 8'd3;
         end
`ifdef T1_TRACE_WINDOW_EN
         dump_active <= (cycle_nxt >= dump_start) && ((dump_end == '0) || (cycle_nxt < dump_end));
`endif
      end
   end

   // Status outputs decoded from the FSM state and the latched fault code
   always_comb begin
      state   = st;
      done    = (st == S_DONE);
      timeout = (st == S_FAULT) && (error_code != 8'd3);
   end

endmodule

// File: tb/tb_t1_run_controller.sv
// Directed bench for t1_run_controller with NUM_DOMAINS=3, other defaults.
// Trace-window checks compile only when T1_TRACE_WINDOW_EN is defined.
module tb_t1_run_controller;

   logic        clock;
   logic        reset;
   logic        commit_valid;
   logic        finish_req;
   logic [2:0]  idle;
   logic [31:0] wdg_limit;
   logic [2:0]  domain_reset;
   logic        init_flag;
   logic [63:0] cycle;
   logic [2:0]  state;
   logic        done;
   logic        timeout;
   logic [7:0]  error_code;
`ifdef T1_TRACE_WINDOW_EN
   logic [63:0] dump_start;
   logic [63:0] dump_end;
   logic        dump_active;
`endif

   int checks   = 0;
   int failures = 0;

   t1_run_controller #(.NUM_DOMAINS(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .commit_valid (commit_valid),
      .finish_req   (finish_req),
      .idle         (idle),
      .wdg_limit    (wdg_limit),
`ifdef T1_TRACE_WINDOW_EN
      .dump_start   (dump_start),
      .dump_end     (dump_end),
      .dump_active  (dump_active),
`endif
      .domain_reset (domain_reset),
      .init_flag    (init_flag),
      .cycle        (cycle),
      .state        (state),
      .done         (done),
      .timeout      (timeout),
      .error_code   (error_code)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_state"}, 64'(state), 64'd0);
      check_eq({tag, "_dr"}, 64'(domain_reset), 64'd7);
      check_eq({tag, "_init"}, 64'(init_flag), 64'd1);
      check_eq({tag, "_cycle"}, cycle, 64'd0);
      check_eq({tag, "_done"}, 64'(done), 64'd0);
      check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
      check_eq({tag, "_err"}, 64'(error_code), 64'd0);
`ifdef T1_TRACE_WINDOW_EN
      check_eq({tag, "_dump"}, 64'(dump_active), 64'd0);
`endif
   endtask

   task automatic pulse_reset(input string tag);
      reset = 1'b0;
      step();
      check_reset(tag);
      reset = 1'b1;
   endtask

   task automatic boot(input string tag);
      repeat (9) step();
      check_eq({tag, "_run_state"}, 64'(state), 64'd2);
      check_eq({tag, "_run_cycle"}, cycle, 64'd9);
      check_eq({tag, "_run_dr"}, 64'(domain_reset), 64'd0);
   endtask

   initial begin
      clock        = 1'b0;
      reset        = 1'b0;
      commit_valid = 1'b0;
      finish_req   = 1'b0;
      idle         = 3'b000;
      wdg_limit    = 32'd10;
`ifdef T1_TRACE_WINDOW_EN
      dump_start   = 64'd0;
      dump_end     = 64'd0;
`endif

      // Power-on reset and staggered release
      repeat (3) step();
      check_reset("por");
      reset = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         check_eq("seq_cycle", cycle, 64'(c));
         check_eq("seq_dr", 64'(domain_reset), (c < 5) ? 64'd7 : (c < 7) ? 64'd6 : (c < 9) ? 64'd4 : 64'd0);
         check_eq("seq_state", 64'(state), (c < 5) ? 64'd0 : (c < 9) ? 64'd1 : 64'd2);
         if (c == 1) check_eq("init_fall", 64'(init_flag), 64'd0);
      end

      // Watchdog with no commits: fires 10 cycles after RUN entry
      for (int c = 10; c <= 18; c++) begin
         step();
         check_eq("wdg_wait_state", 64'(state), 64'd2);
      end
      step();
      check_eq("wdg_state", 64'(state), 64'd5);
      check_eq("wdg_timeout", 64'(timeout), 64'd1);
      check_eq("wdg_err", 64'(error_code), 64'd1);
      check_eq("wdg_cycle", cycle, 64'd19);
      check_eq("wdg_dr", 64'(domain_reset), 64'd0);
      repeat (3) step();
      check_eq("fault_frozen_cycle", cycle, 64'd19);
      check_eq("fault_absorb", 64'(state), 64'd5);

      // Reset from FAULT, then commit on the would-be timeout cycle
      pulse_reset("fault_rst");
      boot("race");
      repeat (9) step();
      commit_valid = 1'b1;
      step();
      commit_valid = 1'b0;
      check_eq("race_state", 64'(state), 64'd2);
      check_eq("race_timeout", 64'(timeout), 64'd0);
      repeat (9) step();
      check_eq("race_pre_state", 64'(state), 64'd2);
      step();
      check_eq("race_fire_state", 64'(state), 64'd5);
      check_eq("race_fire_err", 64'(error_code), 64'd1);
      check_eq("race_fire_cycle", cycle, 64'd29);

      // Clean finish; finish_req before RUN must not be latched
      pulse_reset("race_rst");
      wdg_limit  = 32'd0;
      idle       = 3'b111;
      finish_req = 1'b1;
      repeat (8) step();
      finish_req = 1'b0;
      step();
      check_eq("early_fin_state9", 64'(state), 64'd2);
      step();
      check_eq("early_fin_state10", 64'(state), 64'd2);
      finish_req = 1'b1;
      step();
      finish_req = 1'b0;
      check_eq("drain_entry", 64'(state), 64'd3);
      for (int c = 12; c <= 18; c++) begin
         idle = (c == 14) ? 3'b101 : 3'b111;
         step();
         check_eq("drain_state", 64'(state), (c == 18) ? 64'd4 : 64'd3);
         check_eq("drain_done", 64'(done), (c == 18) ? 64'd1 : 64'd0);
      end
      check_eq("done_err", 64'(error_code), 64'd0);
      check_eq("done_timeout", 64'(timeout), 64'd0);
      repeat (2) step();
      check_eq("done_frozen_cycle", cycle, 64'd18);
      check_eq("done_sticky", 64'(done), 64'd1);
      check_eq("done_dr", 64'(domain_reset), 64'd0);

      // Reset from DONE, then reset from DRAIN
      pulse_reset("done_rst");
      boot("redo");
      finish_req = 1'b1;
      step();
      finish_req = 1'b0;
      idle = 3'b000;
      check_eq("drain2_state", 64'(state), 64'd3);
      repeat (2) step();
      check_eq("drain2_hold", 64'(state), 64'd3);
      pulse_reset("drain_rst");

      // Watchdog expiring in DRAIN
      wdg_limit = 32'd10;
      boot("dwdg");
      finish_req = 1'b1;
      step();
      finish_req = 1'b0;
      check_eq("dwdg_drain", 64'(state), 64'd3);
      repeat (8) step();
      check_eq("dwdg_pre", 64'(state), 64'd3);
      step();
      check_eq("dwdg_state", 64'(state), 64'd5);
      check_eq("dwdg_err", 64'(error_code), 64'd2);
      check_eq("dwdg_timeout", 64'(timeout), 64'd1);

`ifdef T1_TRACE_WINDOW_EN
      // Trace window 20..29, trace end at 30
      pulse_reset("trace_rst");
      wdg_limit  = 32'd0;
      dump_start = 64'd20;
      dump_end   = 64'd30;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (c >= 19) check_eq("dump_active", 64'(dump_active), (c >= 20 && c <= 29) ? 64'd1 : 64'd0);
      end
      check_eq("trace_state", 64'(state), 64'd5);
      check_eq("trace_err", 64'(error_code), 64'd3);
      check_eq("trace_timeout", 64'(timeout), 64'd0);
      check_eq("trace_cycle", cycle, 64'd30);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/t1_run_controller.md
Name: t1_run_controller

Overview:
Synthesizable run controller for the T1 emulation top. It replaces the free-running testbench clock/reset/init sequencing with a parametrised, clocked sequencer.
- Holds and then staggers reset release across NUM_DOMAINS reset domains.
- Generates the init flag.
- Runs a commit-interval watchdog.
- Qualifies the DPI finish request against per-domain idle before signalling done.
- Sits between the cosim DPI shim and the DUT reset/idle pins.

Parameters:
- NUM_DOMAINS, 2: number of independently released reset domains (1..16).
- RESET_HOLD_CYCLES, 5: cycles all domains stay in reset after controller reset deasserts; value 0 behaves as 1.
- STAGGER_CYCLES, 2: cycle gap between consecutive domain reset releases; 0 releases all domains together.
- INIT_CYCLES, 1: cycles init_flag stays high after controller reset deasserts; 0 drops it on the first cycle.
- WATCHDOG_WIDTH, 32: width of the commit-interval counter and limit.
- CYCLE_WIDTH, 64: width of the cycle counter.
- IDLE_STABLE_CYCLES, 4: consecutive all-idle cycles required to finish (minimum 1).

Ports:
- clock, input, 1: sole clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low.
- commit_valid, input, 1: one pulse per retired instruction.
- finish_req, input, 1: DPI-side request to end the run.
- idle, input, NUM_DOMAINS: per-domain idle.
- wdg_limit, input, WATCHDOG_WIDTH: timeout in cycles; 0 disables the watchdog.
- domain_reset, output, NUM_DOMAINS: active-high reset per domain.
- init_flag, output, 1: high during the init window.
- cycle, output, CYCLE_WIDTH: cycles since reset release.
- state, output, 3: current FSM state encoding.
- done, output, 1: successful completion, sticky.
- timeout, output, 1: watchdog fired, sticky.
- error_code, output, 8: 0 none, 1 timeout in RUN, 2 timeout in DRAIN, 3 trace end reached.

Behaviour:
- Reset (reset==0 at an edge):
  - state=HOLD(0); domain_reset all 1; init_flag=1; cycle=0; done=0; timeout=0; error_code=0.
  - All internal counters are cleared.
  - Reset asserted mid-run from any state, including DONE or FAULT, returns to these values on the next edge.
- FSM encodings: HOLD=0, RELEASE=1, RUN=2, DRAIN=3, DONE=4, FAULT=5.
- cycle:
  - Increments by 1 every edge with reset==1 in HOLD, RELEASE, RUN and DRAIN.
  - Saturates at all-ones.
  - Frozen in DONE and FAULT.
- init_flag: clears once cycle reaches INIT_CYCLES; independent of the FSM.
- HOLD: stays max(RESET_HOLD_CYCLES,1) cycles, then goes to RELEASE.
- RELEASE:
  - Domain i deasserts its reset exactly i*STAGGER_CYCLES cycles after RELEASE entry; domain 0 deasserts on the entry edge.
  - On the edge domain NUM_DOMAINS-1 releases, the FSM goes to RUN.
  - Releases are monotonic; no re-assert except on controller reset.
- Watchdog counter:
  - Counts in RUN and DRAIN; cleared on commit_valid and on RUN entry.
  - Fires when wdg_limit!=0 and counter+1==wdg_limit on a cycle without commit_valid.
  - A commit on the same cycle as the would-be timeout wins: no fire.
- RUN:
  - On watchdog fire: go to FAULT, timeout=1, error_code=1.
  - Else if finish_req==1: go to DRAIN.
  - If finish_req and timeout coincide, the timeout wins.
  - finish_req before RUN is ignored, not latched.
- DRAIN:
  - The finish request stays latched; finish_req falling does not leave DRAIN.
  - An idle-stable counter increments while &idle, and clears on any cycle where idle is not all ones.
  - On reaching IDLE_STABLE_CYCLES: go to DONE, done=1.
  - Watchdog fire: go to FAULT, error_code=2.
  - Watchdog beats idle completion on the same cycle.
- DONE and FAULT: absorbing until controller reset; domain_reset stays deasserted.

Optional Feature:
Macro T1_TRACE_WINDOW_EN.
- Enabled:
  - Adds inputs dump_start and dump_end (each CYCLE_WIDTH) and output dump_active (reset 0).
  - dump_active=1 when cycle>=dump_start and (dump_end==0 or cycle<dump_end).
  - When cycle==dump_end (with dump_end!=0) in RUN or DRAIN: go to FAULT, error_code=3. This has lower priority than a watchdog timeout on the same cycle.
- Disabled: these ports are absent and error_code 3 is never produced.

Test Plan:
- Reset sequencing, defaults, NUM_DOMAINS=3, reset low 3 cycles then high:
  - init_flag falls after 1 cycle.
  - domain_reset goes 111 -> 110 at cycle 5, 100 at 7, 000 at 9.
  - state=RUN at cycle 9.
- Watchdog, wdg_limit=10, no commits after RUN entry: timeout=1, error_code=1, state=FAULT exactly 10 cycles after RUN entry; cycle frozen.
- Commit/timeout race, wdg_limit=10, commit_valid on the 10th cycle: no timeout; counter restarts; the next fire is 10 cycles later.
- Clean finish:
  - finish_req pulses 1 cycle in RUN; idle=11 except one 0 glitch after 2 cycles; IDLE_STABLE_CYCLES=4.
  - Result: done=1 on the 4th consecutive all-idle cycle after the glitch.
- Reset mid-run: reset pulled low in DRAIN and in FAULT -> all outputs return to reset values next edge; full sequence repeats.
- T1_TRACE_WINDOW_EN, dump_start=20, dump_end=30:
  - dump_active is high for cycles 20..29.
  - At cycle 30: FAULT, error_code=3.
